weight_serializer: RTL and testbench
====================================

# weight_serializer

Bit-serial weight feeder for the accelerator's multiply path. Accepts 16-bit weight words, each paired with the neuron value it multiplies, over a valid/ready handshake. It emits each weight one bit per cycle, LSB first, on `Weight_bit` with a matching `enable`, and holds the paired neuron value stable on `input_neuron` for the whole word. It drives the `Mult` unit directly. A one-word holding buffer lets consecutive words stream with no idle cycle between them.

## Interface
- `WIDTH`, 16, weight and neuron word width; also the number of serial bits per word.
- `CNT_W`, 4, width of the bit counter; must satisfy 2^CNT_W >= WIDTH.
- `clk` in 1: single clock; all logic samples on the rising edge.
- `reset` in 1: synchronous, active-high; overrides every other input.
- `weight_in` in WIDTH: weight word to serialize.
- `neuron_in` in WIDTH: neuron value paired with `weight_in`.
- `weight_valid` in 1: `weight_in` and `neuron_in` are valid.
- `weight_ready` out 1: holding buffer can accept a word.
- `stall` in 1: downstream freeze; the shifter holds state while high.
- `Weight_bit` out 1: current serial weight bit, to `Mult`.
- `enable` out 1: `Weight_bit` is valid this cycle, to `Mult`.
- `input_neuron` out WIDTH: neuron value for the word being shifted, to `Mult`.
- `first` out 1: high with bit 0 of each word.
- `last` out 1: high with bit WIDTH-1 of each word.

## Operation
- Storage:
  - holding buffer `buf_w`/`buf_n` with `buf_full` flag;
  - shift register `sh` (WIDTH-1 bits);
  - bit counter `cnt`;
  - state IDLE / SHIFT.
- Accept: the word is captured at an edge where `weight_valid && weight_ready`. That edge stores `buf_w <= weight_in`, `buf_n <= neuron_in` and sets `buf_full <= 1`.
- `weight_ready = !buf_full`. It depends only on registers, with no combinational path from `weight_valid`.
- Load condition: `buf_full` is 1 and `stall` is 0, and either state is IDLE, or state is SHIFT with `cnt == WIDTH-1` (the last bit is being consumed).
- On load, all of the following happen on the same edge:
  - `Weight_bit <= buf_w[0]`;
  - `sh <= buf_w[WIDTH-1:1]`;
  - `input_neuron <= buf_n`;
  - `cnt <= 0`;
  - `enable <= 1`, `first <= 1`, `last <= (WIDTH==1)`;
  - state becomes SHIFT;
  - `buf_full <= 0`.
- If a new word is accepted on the same edge as a load, the buffer refills and `buf_full` stays 1. This cannot happen while `weight_ready` is 0.
- SHIFT, `stall` = 0, `cnt < WIDTH-1`:
  - `Weight_bit <= sh[0]`, `sh <= sh >> 1`, `cnt <= cnt+1`;
  - `first <= 0`;
  - `last <= (cnt+1 == WIDTH-1)`.
- SHIFT, `cnt == WIDTH-1`, no load: go to IDLE with `enable`, `first`, `last` and `Weight_bit` all 0. `input_neuron` keeps its last value.
- `stall` = 1: no register in the shift path changes; outputs hold their values. The buffer may still accept a word if `weight_ready` is 1.
- Reset: every register clears. Reset takes priority over a simultaneous accept or load.

## Timing
- Reset values:
  - `weight_ready` = 1;
  - `Weight_bit`, `enable`, `first`, `last` = 0;
  - `input_neuron` = 0;
  - state IDLE, `cnt` = 0, `buf_full` = 0.
- Latency from IDLE: accept at edge E0 gives a load at E1. Bit 0 is presented in the cycle after E1, and bit k in the cycle after E1+k.
- Per word, `enable` is high for exactly WIDTH non-stalled cycles. `first` and `last` are each high for one such cycle.
- Back-to-back words: if the next word is buffered before the last bit, bit 0 of the next word follows bit WIDTH-1 with no gap. Steady throughput is 1 word per WIDTH cycles.
- Reset mid-word: the word in progress and any buffered word are discarded. `enable` is 0 in the cycle after the reset edge, with no partial resume.
- Stall on the last bit: `last` stays high until the cycle after `stall` falls, then the load or the IDLE transition proceeds.

## Test plan
- **Single word.** Reset, then send `weight_in`=0x5555, `neuron_in`=0x0801.
  - `Weight_bit` = 1,0,1,0,… for 16 cycles; `enable` high 16 cycles.
  - `first` on bit 0, `last` on bit 15; `input_neuron`=0x0801 throughout.
  - Then return to IDLE.
- **Back-to-back.** Send 0x5555 then 0xFFFF; the second is accepted mid-word.
  - 32 contiguous `enable` cycles; bits 16–31 all 1.
  - `input_neuron` switches at bit 16.
- **Backpressure.** Hold `weight_valid` high with 3 words queued.
  - `weight_ready` drops after each accept and rises on the edge of each load.
  - No word lost or duplicated; output order is word0, word1, word2.
- **Stall.** Send 0x8001 and assert `stall` for 3 cycles at bit 7.
  - Bit 7 (value 0) is held 4 cycles; total `enable`-high cycles = 19.
  - Bit 15 = 1, with `last` high.
- **Reset mid-word.** Send 0xA5A5, assert `reset` at bit 5 with a second word buffered.
  - After reset: all outputs 0, `weight_ready`=1.
  - No further `enable` until a new word is sent.
- **Zero weight.** Send `weight_in`=0x0000.
  - `enable` high 16 cycles with `Weight_bit`=0 throughout.
  - `first` and `last` behave as in the single-word case.

Source files
------------

// File: rtl/weight_serializer.sv
// weight_serializer: buffers weight/neuron pairs and streams each weight LSB-first into Mult.
module weight_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] weight_in,
  input  logic [WIDTH-1:0] neuron_in,
  input  logic             weight_valid,
  output logic             weight_ready,
  input  logic             stall,
  output logic             Weight_bit,
  output logic             enable,
  output logic [WIDTH-1:0] input_neuron,
  output logic             first,
  output logic             last
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] buf_w, buf_n;
  logic buf_full;
  logic [WIDTH-2:0] sh;
  logic [CNT_W-1:0] cnt;
  logic at_end, accept, load, advance;
  assign weight_ready = !buf_full;
  always_comb begin
    at_end = cnt == CNT_W'(WIDTH - 1);
    accept = weight_valid && weight_ready;
    load = buf_full && !stall && (state == IDLE || at_end);
    advance = state == SHIFT && !stall;
    state_nx = load ? SHIFT : (advance && at_end) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // Loading on the last bit is what lets consecutive words stream gap-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_w <= '0;
      buf_n <= '0;
      buf_full <= 1'b0;
      sh <= '0;
      cnt <= '0;
      Weight_bit <= 1'b0;
      enable <= 1'b0;
      input_neuron <= '0;
      first <= 1'b0;
      last <= 1'b0;
    end else begin
      if (accept) begin
        buf_w <= weight_in;
        buf_n <= neuron_in;
      end
      buf_full <= accept || (buf_full && !load);
      if (load) begin
        Weight_bit <= buf_w[0];
        sh <= buf_w[WIDTH-1:1];
        input_neuron <= buf_n;
        cnt <= '0;
        enable <= 1'b1;
        first <= 1'b1;
        last <= WIDTH == 1;
      end else if (advance && !at_end) begin
        Weight_bit <= sh[0];
        sh <= sh >> 1;
        cnt <= cnt + 1'b1;
        first <= 1'b0;
        last <= cnt == CNT_W'(WIDTH - 2);
      end else if (advance) begin
        Weight_bit <= 1'b0;
        enable <= 1'b0;
        first <= 1'b0;
        last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_weight_serializer.sv
// tb_weight_serializer: directed checks of serialization, streaming, stall and reset.
module tb_weight_serializer;
  logic clk = 0, reset = 1, weight_valid = 0, stall = 0;
  logic [15:0] weight_in = '0, neuron_in = '0;
  logic weight_ready, Weight_bit, enable, first, last;
  logic [15:0] input_neuron;
  int checks = 0, errors = 0;
  logic [63:0] cap_bits;
  logic [15:0] cap_nrn [64];
  int cap_n, cap_f, cap_l, cap_fpos, cap_lpos, en_cnt;
  weight_serializer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .weight_in(weight_in), .neuron_in(neuron_in),
    .weight_valid(weight_valid), .weight_ready(weight_ready), .stall(stall),
    .Weight_bit(Weight_bit), .enable(enable), .input_neuron(input_neuron),
    .first(first), .last(last)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] w, input logic [15:0] n);
    bit ok = 0;
    weight_in = w;
    neuron_in = n;
    weight_valid = 1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = weight_ready;
      tick();
    end
    weight_valid = 0;
    chk("accepted", 64'(ok), 1);
    chk("rdy_drop", 64'(weight_ready), 0);
  endtask
  task automatic capture(input int budget);
    bit done = 0;
    cap_bits = '0;
    cap_n = 0;
    cap_f = 0;
    cap_l = 0;
    cap_fpos = -1;
    cap_lpos = -1;
    for (int i = 0; i < budget && !done; i++) begin
      if (enable) begin
        cap_bits[cap_n] = Weight_bit;
        cap_nrn[cap_n] = input_neuron;
        if (first) begin cap_f++; if (cap_fpos < 0) cap_fpos = cap_n; end
        if (last) begin cap_l++; cap_lpos = cap_n; end
        cap_n++;
        tick();
      end else if (cap_n > 0) done = 1;
      else tick();
    end
    chk("cap_done", 64'(done), 1);
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_en"}, 64'(enable), 0);
    chk({tag, "_bit"}, 64'(Weight_bit), 0);
    chk({tag, "_fl"}, {first, last}, 0);
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    idle_chk("rst");
    chk("rst_rdy", 64'(weight_ready), 1);
    chk("rst_nrn", 64'(input_neuron), 0);
    // single word
    weight_in = 16'h5555;
    neuron_in = 16'h0801;
    weight_valid = 1;
    tick();
    weight_valid = 0;
    chk("sw_rdy_drop", 64'(weight_ready), 0);
    chk("sw_en_e0", 64'(enable), 0);
    tick();
    chk("sw_rdy_rise", 64'(weight_ready), 1);
    chk("sw_bit0", {enable, first, Weight_bit}, 3'b111);
    chk("sw_nrn", 64'(input_neuron), 16'h0801);
    capture(40);
    chk("sw_n", 64'(cap_n), 16);
    chk("sw_bits", cap_bits, 64'h5555);
    chk("sw_first", {32'(cap_f), 32'(cap_fpos)}, {32'd1, 32'd0});
    chk("sw_last", {32'(cap_l), 32'(cap_lpos)}, {32'd1, 32'd15});
    chk("sw_nrn15", 64'(cap_nrn[15]), 16'h0801);
    idle_chk("sw_end");
    chk("sw_nrn_keep", 64'(input_neuron), 16'h0801);
    // back-to-back
    fork
      capture(80);
      begin send(16'h5555, 16'h0801); send(16'hFFFF, 16'h1234); end
    join
    chk("bb_n", 64'(cap_n), 32);
    chk("bb_bits", cap_bits, 64'hFFFF5555);
    chk("bb_nrn", {cap_nrn[15], cap_nrn[16], cap_nrn[31]}, {16'h0801, 16'h1234, 16'h1234});
    chk("bb_fl", {32'(cap_f), 32'(cap_l)}, {32'd2, 32'd2});
    // backpressure: three words with valid held
    fork
      capture(120);
      begin send(16'h1234, 16'h0001); send(16'hBEEF, 16'h0002); send(16'h0F0F, 16'h0003); end
    join
    chk("bp_n", 64'(cap_n), 48);
    chk("bp_bits", cap_bits, 64'h0F0FBEEF1234);
    chk("bp_nrn", {cap_nrn[0], cap_nrn[16], cap_nrn[47]}, {16'h1, 16'h2, 16'h3});
    // stall at bit 7
    fork
      capture(80);
      send(16'h8001, 16'h00AA);
      begin
        for (int i = 0; i < 10 && !enable; i++) tick();
        repeat (7) tick();
        stall = 1;
        repeat (3) tick();
        stall = 0;
      end
    join
    chk("st_n", 64'(cap_n), 19);
    chk("st_bits", cap_bits, 64'h40001);
    chk("st_last", {32'(cap_l), 32'(cap_lpos)}, {32'd1, 32'd18});
    // reset mid-word with a second word buffered
    fork
      begin send(16'hA5A5, 16'h0011); send(16'h00FF, 16'h0022); end
      begin
        for (int i = 0; i < 10 && !enable; i++) tick();
        repeat (5) tick();
        reset = 1;
        tick();
        reset = 0;
      end
    join
    idle_chk("mr");
    chk("mr_rdy", 64'(weight_ready), 1);
    chk("mr_nrn", 64'(input_neuron), 0);
    en_cnt = 0;
    repeat (20) begin
      tick();
      if (enable) en_cnt++;
    end
    chk("mr_quiet", 64'(en_cnt), 0);
    // zero weight
    fork
      capture(40);
      send(16'h0000, 16'h7777);
    join
    chk("zw_n", 64'(cap_n), 16);
    chk("zw_bits", cap_bits, 0);
    chk("zw_first", {32'(cap_f), 32'(cap_fpos)}, {32'd1, 32'd0});
    chk("zw_last", {32'(cap_l), 32'(cap_lpos)}, {32'd1, 32'd15});
    chk("zw_nrn", 64'(cap_nrn[0]), 16'h7777);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
